// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the EX stage.
// Holds the architectural HI/LO registers. MULT/MULTU complete after MUL_LAT
// cycles, DIV/DIVU after 32 cycles of restoring radix-2 division. MTHI/MTLO
// write HI/LO in a single edge. busy stalls the front end while an op runs.
module md_unit #(
  parameter int MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int          CNT_W    = 5;
  localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(31);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t            state_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       hi_q;
  logic [31:0]       lo_q;

  // Captured operands and division working registers (no reset: pure data).
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic              sgn_q;
  logic [31:0]       rem_q;
  logic [31:0]       quo_q;
  logic [31:0]       dvs_q;
  logic              qneg_q;
  logic              rneg_q;
  logic              dz_q;

  logic              issue_md;
  logic              op_signed;
  logic [31:0]       abs_a;
  logic [31:0]       abs_b;

  logic signed [63:0] mul_a;
  logic signed [63:0] mul_b;
  logic signed [63:0] prod;

  logic [32:0]       part;
  logic [32:0]       diff;
  logic [31:0]       rem_d;
  logic [31:0]       quo_d;
  logic [31:0]       quo_fix;
  logic [31:0]       rem_fix;

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Operand conditioning at issue time: magnitudes for signed division.
  always_comb begin
    issue_md  = 1'b0;
    op_signed = 1'b0;
    abs_a     = A;
    abs_b     = B;
    if (state_q == S_IDLE && start && !op[2]) begin
      issue_md = 1'b1;
    end
    op_signed = ~op[0];
    if (op_signed && A[31]) abs_a = -A;
    if (op_signed && B[31]) abs_b = -B;
  end

  // 64-bit product; sign extension selects signed vs unsigned multiply.
  always_comb begin
    mul_a = {{32{sgn_q & a_q[31]}}, a_q};
    mul_b = {{32{sgn_q & b_q[31]}}, b_q};
    prod  = mul_a * mul_b;
  end

  // One restoring-division step plus final sign fix of quotient/remainder.
  always_comb begin
    part = {rem_q, quo_q[31]};
    diff = part - {1'b0, dvs_q};
    if (part >= {1'b0, dvs_q}) begin
      rem_d = diff[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end else begin
      rem_d = part[31:0];
      quo_d = {quo_q[30:0], 1'b0};
    end
    quo_fix = qneg_q ? -quo_d : quo_d;
    rem_fix = rneg_q ? -rem_d : rem_d;
  end

  // Datapath capture at issue and iterative division shifting.
  always_ff @(posedge clk) begin
    if (issue_md) begin
      a_q    <= A;
      b_q    <= B;
      sgn_q  <= op_signed;
      rem_q  <= 32'd0;
      quo_q  <= abs_a;
      dvs_q  <= abs_b;
      qneg_q <= op_signed & (A[31] ^ B[31]);
      rneg_q <= op_signed & A[31];
      dz_q   <= (B == 32'd0);
    end else if (state_q == S_DIV) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  // Control FSM with registered busy and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                state_q <= S_MUL;
                busy_q  <= 1'b1;
                cnt_q   <= MUL_CNT0;
              end
              OP_DIV, OP_DIVU: begin
                state_q <= S_DIV;
                busy_q  <= 1'b1;
                cnt_q   <= DIV_CNT0;
              end
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            hi_q    <= prod[63:32];
            lo_q    <= prod[31:0];
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DIV: begin
          if (cnt_q == '0) begin
            if (dz_q) begin
              hi_q <= a_q;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against an
// arithmetic reference model of HI/LO and busy duration.
module tb_md_unit;

  localparam int MUL_LAT = 5;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  md_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: result {hi,lo} of an op from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: res = 64'(sa * sb);
      3'd1: res = ua * ub;
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
      3'd4: res = {a, l};
      3'd5: res = {h, a};
      default: res = {h, l};
    endcase
    return res;
  endfunction

  function automatic int exp_busy(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd1) return MUL_LAT;
    if (o == 3'd2 || o == 3'd3) return 32;
    return 0;
  endfunction

  // Pulse start for one edge; caller is 1 time unit after a rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count cycles with busy high. inj_kind 1 pulses a start at cycle inj_at,
  // inj_kind 2 drives reset at cycle inj_at.
  task automatic wait_idle(output int n, input int inj_kind, input int inj_at,
                           input logic [2:0] inj_op, input logic [31:0] inj_a);
    bit injected;
    n = 0;
    while (busy && n < 100) begin
      n++;
      injected = 1'b0;
      if (inj_kind == 1 && n == inj_at) begin
        start = 1'b1; op = inj_op; A = inj_a; injected = 1'b1;
      end
      if (inj_kind == 2 && n == inj_at) begin
        rst = 1'b0; injected = 1'b1;
      end
      @(posedge clk);
      #1;
      if (injected) begin
        start = 1'b0;
        rst   = 1'b1;
      end
    end
    if (n >= 100) chk("busy_timeout", 64'(n), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    logic [63:0] r;
    r = model(o, a, b, hi_m, lo_m);
    issue(o, a, b);
    wait_idle(n, 0, 0, 3'd0, 32'd0);
    hi_m = r[63:32];
    lo_m = r[31:0];
    chk({tag, "_cycles"}, 64'(n), 64'(exp_busy(o)));
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, hi_m});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, lo_m});
  endtask

  initial begin
    int n;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b0; start = 1'b0; op = 3'd0; A = '0; B = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("multu", 3'd1, 32'hFFFF_FFFD, 32'd7);
    chk("multu_const", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
    run_op("divu", 3'd3, 32'd100, 32'd7);
    chk("divu_const", {hi, lo}, {32'd2, 32'd14});
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("divu_z", 3'd3, 32'h1234, 32'd0);
    chk("divu_z_const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_op("div_z", 3'd2, 32'hFFFF_FF00, 32'd0);

    // MTHI pulsed while dividing must be ignored.
    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n, 1, 10, 3'd4, 32'hDEAD_BEEF);
    chk("ign_cycles", 64'(n), 64'd32);
    chk("ign_hilo", {hi, lo}, {32'd2, 32'd14});
    hi_m = 32'd2; lo_m = 32'd14;
    // Back-to-back MTLO immediately after busy falls.
    run_op("mtlo_b2b", 3'd5, 32'h55, 32'd0);
    chk("mtlo_busy", {63'd0, busy}, 64'd0);

    run_op("mthi", 3'd4, 32'hAAAA_0000, 32'd0);
    run_op("noop6", 3'd6, 32'h1111_1111, 32'd2);
    run_op("noop7", 3'd7, 32'h2222_2222, 32'd3);

    // Reset in the middle of a division aborts it.
    issue(3'd2, 32'd1000, 32'd3);
    wait_idle(n, 2, 15, 3'd0, 32'd0);
    chk("rst_mid_cycles", 64'(n), 64'd15);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    hi_m = '0; lo_m = '0;
    run_op("mult_after_rst", 3'd0, 32'd2, 32'd3);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
      run_op("rand", ro, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, replacing the single-cycle multiply/divide path.
- Captures operands from the EX forwarding muxes (forwarded rs/rt) when an EX-stage instruction issues MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Holds architectural HI/LO registers. HI/LO feed the EX result mux for MFHI/MFLO.
- busy goes to the stall controller, which freezes PC/IF_ID and bubbles ID_EX while busy is high.

Parameters:
- MUL_LAT, 5, cycles busy is held high for MULT/MULTU (legal range 1..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- start  in  1  issue strobe from EX decode, valid for one cycle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- A  in  32  operand rs (forwarded).
- B  in  32  operand rt (forwarded).
- busy  out  1  operation in progress; HI/LO are not yet valid.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE, busy=0, hi=0, lo=0, counter=0. Reset overrides all other inputs. Reset mid-operation aborts it and no result is written.
- State machine IDLE / MUL / DIV. busy=1 exactly when state is MUL or DIV; busy is registered.
- IDLE, start=1, op=MTHI: hi<=A at this edge. No busy, stays IDLE.
- IDLE, start=1, op=MTLO: lo<=A at this edge. No busy, stays IDLE.
- IDLE, start=1, op=MULT/MULTU:
  - Capture A, B and signedness; go to MUL with counter=MUL_LAT-1.
  - On each subsequent edge in MUL: if counter==0, write {hi,lo}<=64-bit product and go to IDLE; else decrement counter.
  - busy is high for exactly MUL_LAT cycles. New hi/lo are visible the cycle after busy falls.
- IDLE, start=1, op=DIV/DIVU:
  - Capture absolute values (DIV) or raw values (DIVU) plus result signs; go to DIV with counter=31.
  - Restoring radix-2 algorithm: one quotient bit per edge, 32 edges.
  - On the 32nd edge, write lo=quotient and hi=remainder with sign fix applied, then go to IDLE. busy is high for exactly 32 cycles.
- Signed division: quotient truncates toward zero; remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (B==0): still 32 cycles busy, then lo=0xFFFFFFFF, hi=A (the original dividend, signed or unsigned alike).
- MULT is a signed 32x32->64 multiply; MULTU is unsigned. hi=product[63:32], lo=product[31:0].
- start while busy=1 is ignored: no capture, no MTHI/MTLO write. The stall logic guarantees this does not happen; the unit must still tolerate it.
- start with op=110/111 has no effect.
- hi/lo hold their previous values throughout an operation and change only at the completing edge.
- Back-to-back issue: start may be 1 in the cycle right after busy falls; that issues a new operation.

Test Plan:
- MULT, A=0xFFFFFFFD (-3), B=7, MUL_LAT=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIVU, A=100, B=7 -> busy high exactly 32 cycles; then lo=14, hi=2. DIV, A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV, A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU, A=0x1234, B=0 -> lo=0xFFFFFFFF, hi=0x1234.
- Start DIVU 100/7, then pulse start with MTHI A=0xDEADBEEF at cycle 10 -> ignored; final hi=2, lo=14. Then MTLO A=0x55 in the cycle after busy falls -> lo=0x55, busy stays 0.
- MTHI A=0xAAAA0000 -> hi updates at the next edge, busy never asserts. Then start DIV and drive rst=0 at cycle 15 -> busy=0, hi=0, lo=0 the next cycle. A new MULT 2*3 after reset -> lo=6, hi=0.
